// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and helpers for the sequential binary-to-BCD converter
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_e;

    localparam int DEFAULT_DIGITS = 4;

    function automatic logic [3:0] add3_if_ge5(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

endpackage

// File: rtl/dabble_adjust.sv
// rtl/dabble_adjust.sv - parallel add-3 correction of every BCD nibble before a shift
module dabble_adjust
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic [4*DIGITS-1:0] scratch_i,
    output logic [4*DIGITS-1:0] adjusted_o
);

    for (genvar g = 0; g < DIGITS; g++) begin : g_nibble
        assign adjusted_o[4*g +: 4] = add3_if_ge5(scratch_i[4*g +: 4]);
    end

endmodule

// File: rtl/bcd_converter_seq.sv
// rtl/bcd_converter_seq.sv - iterative double-dabble converter, one input bit per clock, with clamping
module bcd_converter_seq
    import bcd_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int DIGITS    = DEFAULT_DIGITS,
    parameter int SAT_VALUE = 10**DIGITS - 1,
    parameter int CLAMP_NEG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = $clog2(IN_WIDTH + 1);
    localparam int SW = 4 * DIGITS;
    localparam logic [IN_WIDTH-1:0] SAT_BIN = IN_WIDTH'(SAT_VALUE);

    state_e              state_q, state_d;
    logic [IN_WIDTH-1:0] bin_q, bin_d;
    logic [SW-1:0]       scratch_q, scratch_d;
    logic [SW-1:0]       adjusted;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic                unf_pend_q, unf_pend_d;
    logic [SW-1:0]       bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                done_q, done_d;

    logic [IN_WIDTH-1:0] clamped;
    logic                clamp_ovf, clamp_unf;

    dabble_adjust #(.DIGITS(DIGITS)) u_adjust (
        .scratch_i  (scratch_q),
        .adjusted_o (adjusted)
    );

    // Negative-wrap check wins over saturation so an underflowed subtraction reads 0, not 9999.
    always_comb begin
        clamped   = bin_in;
        clamp_ovf = 1'b0;
        clamp_unf = 1'b0;
        if ((CLAMP_NEG != 0) && bin_in[IN_WIDTH-1]) begin
            clamped   = '0;
            clamp_unf = 1'b1;
        end else if (bin_in > SAT_BIN) begin
            clamped   = SAT_BIN;
            clamp_ovf = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        unf_pend_d = unf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d      = clamped;
                    scratch_d  = '0;
                    cnt_d      = CW'(IN_WIDTH);
                    ovf_pend_d = clamp_ovf;
                    unf_pend_d = clamp_unf;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, bin_d} = {adjusted[SW-2:0], bin_q, 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bcd_d   = scratch_q;
                ovf_d   = ovf_pend_q;
                unf_d   = unf_pend_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            unf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            unf_pend_q <= unf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            done_q     <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign bcd_out   = bcd_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// tb/tb_bcd_converter_seq.sv - self-checking bench for bcd_converter_seq
module tb_bcd_converter_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;
    logic        underflow;

    int errors = 0;
    int checks = 0;

    bcd_converter_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin_in    (bin_in),
        .busy      (busy),
        .done      (done),
        .bcd_out   (bcd_out),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: clamp, then split into decimal digits arithmetically.
    task automatic ref_conv(input logic [15:0] v, output logic [15:0] b, output logic o, output logic u);
        int x;
        o = 1'b0;
        u = 1'b0;
        if (v[15]) begin
            x = 0;
            u = 1'b1;
        end else if (int'(v) > 9999) begin
            x = 9999;
            o = 1'b1;
        end else begin
            x = int'(v);
        end
        b = {4'(x / 1000 % 10), 4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
    endtask

    task automatic run_conv(input logic [15:0] v, input string tag);
        logic [15:0] eb;
        logic        eo, eu;
        int          lat, busy_cnt;
        bit          got;
        ref_conv(v, eb, eo, eu);
        start  = 1'b1;
        bin_in = v;
        step();
        start    = 1'b0;
        bin_in   = 16'($urandom);
        busy_cnt = busy ? 1 : 0;
        got      = 1'b0;
        lat      = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            step();
            if (done) begin
                got = 1'b1;
                lat = k;
            end else if (busy) begin
                busy_cnt++;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'd17);
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd17);
        chk({tag, " bcd_out"}, 32'(bcd_out), 32'(eb));
        chk({tag, " overflow"}, 32'(overflow), 32'(eo));
        chk({tag, " underflow"}, 32'(underflow), 32'(eu));
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        step();
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        vec_t vecs[$];
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = 16'd0;
        step();
        step();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset bcd_out", 32'(bcd_out), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset underflow", 32'(underflow), 32'd0);
        reset = 1'b0;
        step();

        vecs.push_back('{16'd1234,  16'h1234, 1'b0, 1'b0});
        vecs.push_back('{16'd9999,  16'h9999, 1'b0, 1'b0});
        vecs.push_back('{16'd10000, 16'h9999, 1'b1, 1'b0});
        vecs.push_back('{16'hFFF4,  16'h0000, 1'b0, 1'b1});
        vecs.push_back('{16'd0,     16'h0000, 1'b0, 1'b0});
        vecs.push_back('{16'h8000,  16'h0000, 1'b0, 1'b1});
        vecs.push_back('{16'h7FFF,  16'h9999, 1'b1, 1'b0});
        vecs.push_back('{16'd1,     16'h0001, 1'b0, 1'b0});
        vecs.push_back('{16'd5005,  16'h5005, 1'b0, 1'b0});
        foreach (vecs[i]) begin
            logic [15:0] eb;
            logic        eo, eu;
            ref_conv(vecs[i].bin, eb, eo, eu);
            chk($sformatf("table%0d model", i), {15'd0, eo, eu, eb[14:0]} ^ 32'(eb[15]) << 17,
                {15'd0, vecs[i].exp_ovf, vecs[i].exp_unf, vecs[i].exp_bcd[14:0]} ^ 32'(vecs[i].exp_bcd[15]) << 17);
            run_conv(vecs[i].bin, $sformatf("table%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            logic [15:0] v;
            case ($urandom_range(0, 2))
                0:       v = 16'($urandom);
                1:       v = 16'($urandom_range(0, 9999));
                default: v = 16'($urandom_range(9990, 10010));
            endcase
            run_conv(v, $sformatf("rand%0d v=%0d", i, v));
        end

        // Start ignored while busy; input changes mid-conversion ignored.
        begin
            int ndone;
            start  = 1'b1;
            bin_in = 16'd42;
            step();
            start = 1'b0;
            ndone = 0;
            for (int k = 1; k <= 40; k++) begin
                start = (k == 3);
                if (k == 3) bin_in = 16'd777;
                if (k == 5) bin_in = 16'd3333;
                step();
                if (done) ndone++;
            end
            start = 1'b0;
            chk("ignore ndone", 32'(ndone), 32'd1);
            chk("ignore bcd_out", 32'(bcd_out), 32'h0042);
        end

        // Continuous start: accepts whenever idle, bin_in tracks the edge index.
        begin
            int          exp_t[$];
            logic [15:0] exp_b[$];
            int          next_free, ndone, t;
            logic [15:0] eb;
            logic        eo, eu;
            next_free = 0;
            ndone     = 0;
            start     = 1'b1;
            for (t = 0; t < 60; t++) begin
                bin_in = 16'(t);
                if (t >= next_free) begin
                    ref_conv(16'(t), eb, eo, eu);
                    exp_t.push_back(t + 17);
                    exp_b.push_back(eb);
                    next_free = t + 18;
                end
                step();
                if (done) begin
                    ndone++;
                    if (exp_t.size() == 0) begin
                        chk("stream unexpected done", 32'(t), 32'hFFFF_FFFF);
                    end else begin
                        chk($sformatf("stream done time %0d", ndone), 32'(t), 32'(exp_t[0]));
                        chk($sformatf("stream bcd %0d", ndone), 32'(bcd_out), 32'(exp_b[0]));
                        void'(exp_t.pop_front());
                        void'(exp_b.pop_front());
                    end
                end
            end
            start = 1'b0;
            while (exp_t.size() > 0 && exp_t[0] >= 60) void'(exp_t.pop_front());
            chk("stream ndone", 32'(ndone), 32'd3);
            chk("stream missing", 32'(exp_t.size()), 32'd0);
        end

        // Reset mid-conversion aborts.
        begin
            int ndone;
            step();
            step();
            step();
            start  = 1'b1;
            bin_in = 16'd5678;
            step();
            start = 1'b0;
            for (int k = 1; k < 9; k++) step();
            reset = 1'b1;
            step();
            reset = 1'b0;
            chk("abort busy", 32'(busy), 32'd0);
            chk("abort bcd_out", 32'(bcd_out), 32'd0);
            chk("abort done", 32'(done), 32'd0);
            ndone = 0;
            for (int k = 0; k < 30; k++) begin
                step();
                if (done) ndone++;
            end
            chk("abort no done", 32'(ndone), 32'd0);
            run_conv(16'd5678, "after_abort");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
